// File: rtl/ram_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : ram_port_arbiter
// Description : Time-slices one 1K x 8 synchronous RAM (registered read,
//               one-cycle latency) between a CPU byte port with a
//               request/acknowledge handshake and a burst scanner that
//               streams consecutive bytes. A free-running slot bit gives
//               even cycles to the scanner and odd cycles to the CPU. The
//               CPU may borrow an even cycle that the scanner leaves unused.
// Ports       : clk, reset             - clock, synchronous active-high reset
//               cpu_req/we/addr/wdata  - CPU request, held until cpu_ack
//               cpu_ack, cpu_rdata     - completion pulse, read data
//               scan_start/base/count  - burst start pulse, first address,
//                                        length (0 = 64)
//               scan_busy/valid/data/done - burst status and byte stream
//               ram_a/in/cs_n/we_n     - RAM control pins (driven in the
//                                        issue cycle itself)
//               ram_out                - RAM registered read data
// Revision    : 1.0 - initial release
// ============================================================================
module ram_port_arbiter #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic              cpu_ack,
    output logic [7:0]        cpu_rdata,
    input  logic              scan_start,
    input  logic [ADDR_W-1:0] scan_base,
    input  logic [5:0]        scan_count,
    output logic              scan_busy,
    output logic              scan_valid,
    output logic [7:0]        scan_data,
    output logic              scan_done,
    output logic [ADDR_W-1:0] ram_a,
    output logic [7:0]        ram_in,
    output logic              ram_cs_n,
    output logic              ram_we_n,
    input  logic [7:0]        ram_out
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_ACK  = 3'd1,
        ST_RD_WAIT = 3'd2,
        ST_RD_ACK  = 3'd3,
        ST_HOLD    = 3'd4
    } cpu_state_t;

    cpu_state_t        r_state;
    cpu_state_t        w_state_next;
    logic              r_slot;
    logic [7:0]        r_cpu_rdata;

    logic              r_scan_busy;
    logic [ADDR_W-1:0] r_scan_addr;
    logic [6:0]        r_scan_left;
    logic              r_pipe_vld;   // scanner read issued last cycle
    logic              r_pipe_last;  // ...and it was the final byte
    logic              r_scan_valid;
    logic              r_scan_done;
    logic [7:0]        r_scan_data;

    logic              w_scan_issue;
    logic              w_cpu_grant;
    logic              w_cpu_issue;
    logic              w_cpu_ack;

    // Issue qualifiers are gated by reset so the RAM is never selected
    // (and never written) while reset is asserted.
    assign w_scan_issue = !reset && r_scan_busy && !r_slot && (r_scan_left != 7'd0);
    assign w_cpu_grant  = r_slot || !w_scan_issue;

    always_comb begin
        w_state_next = r_state;
        w_cpu_issue  = 1'b0;
        w_cpu_ack    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (cpu_req && w_cpu_grant && !reset) begin
                    w_cpu_issue  = 1'b1;
                    w_state_next = cpu_we ? ST_WR_ACK : ST_RD_WAIT;
                end
            end
            ST_WR_ACK: begin
                w_cpu_ack    = 1'b1;
                w_state_next = ST_HOLD;
            end
            ST_RD_WAIT: begin
                w_state_next = ST_RD_ACK;
            end
            ST_RD_ACK: begin
                w_cpu_ack    = 1'b1;
                w_state_next = ST_HOLD;
            end
            ST_HOLD: begin
                // cpu_req is still high here from the finished transaction
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // RAM pins are combinational so the RAM samples them at the end of the
    // issue cycle.
    always_comb begin
        ram_cs_n = 1'b1;
        ram_we_n = 1'b1;
        ram_a    = '0;
        ram_in   = 8'h00;
        if (w_scan_issue) begin
            ram_cs_n = 1'b0;
            ram_a    = r_scan_addr;
            ram_in   = cpu_wdata;
        end else if (w_cpu_issue) begin
            ram_cs_n = 1'b0;
            ram_a    = cpu_addr;
            ram_in   = cpu_wdata;
            ram_we_n = !cpu_we;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_slot       <= 1'b0;
            r_cpu_rdata  <= 8'h00;
            r_scan_busy  <= 1'b0;
            r_scan_addr  <= '0;
            r_scan_left  <= 7'd0;
            r_pipe_vld   <= 1'b0;
            r_pipe_last  <= 1'b0;
            r_scan_valid <= 1'b0;
            r_scan_done  <= 1'b0;
            r_scan_data  <= 8'h00;
        end else begin
            r_state <= w_state_next;
            r_slot  <= ~r_slot;

            if (r_state == ST_RD_WAIT) begin
                r_cpu_rdata <= ram_out;
            end

            // Start is only honoured while idle; busy stays high through
            // the scan_done cycle so a start there is ignored as well.
            if (!r_scan_busy) begin
                if (scan_start) begin
                    r_scan_busy <= 1'b1;
                    r_scan_addr <= scan_base;
                    r_scan_left <= (scan_count == 6'd0) ? 7'd64 : {1'b0, scan_count};
                end
            end else if (r_scan_done) begin
                r_scan_busy <= 1'b0;
            end

            if (w_scan_issue) begin
                r_scan_addr <= r_scan_addr + ADDR_W'(1);
                r_scan_left <= r_scan_left - 7'd1;
            end

            // Two-stage pipeline: RAM output appears the cycle after issue
            // and is captured into scan_data on the following edge.
            r_pipe_vld   <= w_scan_issue;
            r_pipe_last  <= w_scan_issue && (r_scan_left == 7'd1);
            r_scan_valid <= r_pipe_vld;
            r_scan_done  <= r_pipe_vld && r_pipe_last;
            if (r_pipe_vld) begin
                r_scan_data <= ram_out;
            end
        end
    end

    assign cpu_ack    = w_cpu_ack && !reset;
    assign cpu_rdata  = r_cpu_rdata;
    assign scan_busy  = r_scan_busy;
    assign scan_valid = r_scan_valid;
    assign scan_data  = r_scan_data;
    assign scan_done  = r_scan_done;

endmodule
`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_ram_port_arbiter
// Description : Self-checking bench for ram_port_arbiter with a behavioural
//               1K x 8 registered-read RAM and a shadow copy of its contents.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_port_arbiter;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic          cpu_req, cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [7:0]    cpu_wdata;
    logic          cpu_ack;
    logic [7:0]    cpu_rdata;
    logic          scan_start;
    logic [AW-1:0] scan_base;
    logic [5:0]    scan_count;
    logic          scan_busy, scan_valid, scan_done;
    logic [7:0]    scan_data;
    logic [AW-1:0] ram_a;
    logic [7:0]    ram_in;
    logic          ram_cs_n, ram_we_n;
    logic [7:0]    ram_out;

    always #5 clk = ~clk;

    ram_port_arbiter #(.ADDR_W(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_ack    (cpu_ack),
        .cpu_rdata  (cpu_rdata),
        .scan_start (scan_start),
        .scan_base  (scan_base),
        .scan_count (scan_count),
        .scan_busy  (scan_busy),
        .scan_valid (scan_valid),
        .scan_data  (scan_data),
        .scan_done  (scan_done),
        .ram_a      (ram_a),
        .ram_in     (ram_in),
        .ram_cs_n   (ram_cs_n),
        .ram_we_n   (ram_we_n),
        .ram_out    (ram_out)
    );

    // Behavioural RAM: write when selected with we_n low, registered read.
    logic [7:0] mem     [0:1023];
    logic [7:0] exp_mem [0:1023];

    always @(posedge clk) begin
        if (!ram_cs_n) begin
            if (!ram_we_n) mem[ram_a] <= ram_in;
            else           ram_out    <= mem[ram_a];
        end
    end

    // Cycle index since reset; bit 0 is the expected slot.
    int cyc;
    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // All tasks are entered and left 1 ns after a rising edge; outputs are
    // sampled 2 ns after the edge.
    task automatic cpu_op(input logic we, input logic [9:0] addr, input logic [7:0] wd,
                          input logic [7:0] exp_rd, input int max_wait, input bit need_slot1);
        int  w;
        bit  hit;
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wd;
        hit = 1'b0;
        #1;
        for (w = 0; w < 8; w++) begin
            if (ram_cs_n == 1'b0 && ram_a == addr && ram_we_n == !we) begin
                hit = 1'b1;
                break;
            end
            @(posedge clk); #2;
        end
        check("cpu_issue_seen", hit, 1);
        if (!hit) begin
            cpu_req = 1'b0;
            @(posedge clk); #1;
            return;
        end
        check("cpu_issue_wait_ok", (w <= max_wait), 1);
        if (need_slot1) check("cpu_issue_slot1", cyc[0], 1);
        if (we) begin
            check("cpu_wr_ram_in", ram_in, wd);
            exp_mem[addr] = wd;
        end
        @(posedge clk); #2;
        if (!we) begin
            check("cpu_rd_wait_no_ack", cpu_ack, 0);
            @(posedge clk); #2;
            check("cpu_rd_ack", cpu_ack, 1);
            check("cpu_rdata", cpu_rdata, exp_rd);
        end else begin
            check("cpu_wr_ack", cpu_ack, 1);
        end
        @(posedge clk); #1;
        cpu_req = 1'b0;
        #1;
        check("cpu_ack_single_pulse", cpu_ack, 0);
        @(posedge clk); #1;
    endtask

    task automatic burst(input logic [9:0] base, input logic [5:0] cnt, input bit poke_mid);
        int         n, k, issues, last_v;
        logic [9:0] ea;
        n = (cnt == 6'd0) ? 64 : int'(cnt);
        scan_start = 1'b1;
        scan_base  = base;
        scan_count = cnt;
        #1;
        check("scan_busy_in_start_cycle", scan_busy, 0);
        @(posedge clk); #1;
        scan_start = 1'b0;
        #1;
        check("scan_busy_after_start", scan_busy, 1);
        k = 0; issues = 0; last_v = 0;
        for (int t = 0; t < 2 * n + 8; t++) begin
            if (!ram_cs_n && cyc[0] == 1'b0 && issues < n) begin
                ea = base + 10'(issues);
                check("scan_issue_addr", ram_a, ea);
                issues++;
            end
            if (scan_valid) begin
                ea = base + 10'(k);
                check("scan_data", scan_data, exp_mem[ea]);
                if (k > 0) check("scan_valid_spacing", cyc - last_v, 2);
                check("scan_done_flag", scan_done, (k == n - 1));
                last_v = cyc;
                k++;
                if (k == n) break;
            end
            @(posedge clk); #1;
            if (poke_mid && t == 9) begin
                scan_start = 1'b1;
                scan_base  = 10'h200;
                scan_count = 6'd5;
            end else begin
                scan_start = 1'b0;
            end
            #1;
        end
        scan_start = 1'b0;
        check("scan_valid_count", k, n);
        @(posedge clk); #2;
        check("scan_busy_dropped", scan_busy, 0);
        check("scan_no_extra_valid", scan_valid, 0);
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic       we;
        logic [9:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rd;
    } vec_t;

    vec_t vecs [12];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int  found, acks, valids;

        for (int i = 0; i < 1024; i++) begin
            mem[i]     <= 8'(i) ^ 8'h5C;
            exp_mem[i]  = 8'(i) ^ 8'h5C;
        end

        vecs[0]  = '{1'b1, 10'h123, 8'h5A, 8'h00};
        vecs[1]  = '{1'b0, 10'h123, 8'h00, 8'h5A};
        vecs[2]  = '{1'b1, 10'h3FE, 8'h10, 8'h00};
        vecs[3]  = '{1'b1, 10'h3FF, 8'h11, 8'h00};
        vecs[4]  = '{1'b1, 10'h000, 8'h12, 8'h00};
        vecs[5]  = '{1'b1, 10'h001, 8'h13, 8'h00};
        vecs[6]  = '{1'b0, 10'h3FF, 8'h00, 8'h11};
        vecs[7]  = '{1'b0, 10'h000, 8'h00, 8'h12};
        vecs[8]  = '{1'b1, 10'h2AA, 8'h00, 8'h00};
        vecs[9]  = '{1'b0, 10'h2AA, 8'hFF, 8'h00};
        vecs[10] = '{1'b1, 10'h155, 8'hFF, 8'h00};
        vecs[11] = '{1'b0, 10'h155, 8'h00, 8'hFF};

        // Reset with a CPU write request held: RAM must never be written.
        reset      = 1'b1;
        cpu_req    = 1'b1;
        cpu_we     = 1'b1;
        cpu_addr   = 10'h123;
        cpu_wdata  = 8'hEE;
        scan_start = 1'b0;
        scan_base  = '0;
        scan_count = 6'd0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #2;
            check("reset_ram_we_n", ram_we_n, 1);
            check("reset_ram_cs_n", ram_cs_n, 1);
        end
        check("reset_cpu_ack",    cpu_ack, 0);
        check("reset_cpu_rdata",  cpu_rdata, 0);
        check("reset_scan_busy",  scan_busy, 0);
        check("reset_scan_valid", scan_valid, 0);
        check("reset_scan_data",  scan_data, 0);
        check("reset_scan_done",  scan_done, 0);
        check("reset_ram_a",      ram_a, 0);
        check("reset_ram_in",     ram_in, 0);
        cpu_req = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;

        // CPU transactions with no burst running: zero wait.
        for (int i = 0; i < 12; i++) begin
            cpu_op(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rd, 0, 1'b0);
        end

        // Wrapping 4-byte burst over 0x3FE..0x001.
        burst(10'h3FE, 6'd4, 1'b0);

        // Count 0 means 64; mid-burst start pulse must be ignored.
        burst(10'h000, 6'd0, 1'b1);

        // CPU read held during a 16-byte burst.
        fork
            burst(10'h040, 6'd16, 1'b0);
            begin
                repeat (5) @(posedge clk);
                #1;
                cpu_op(1'b0, 10'h123, 8'h00, 8'h5A, 1, 1'b1);
            end
        join

        // Reset in the RD_WAIT cycle while a burst is running.
        scan_start = 1'b1;
        scan_base  = 10'h080;
        scan_count = 6'd16;
        @(posedge clk); #1;
        scan_start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 10'h123;
        #1;
        found = 0;
        for (int w = 0; w < 6; w++) begin
            if (!ram_cs_n && ram_a == 10'h123 && ram_we_n) begin
                found = 1;
                break;
            end
            @(posedge clk); #2;
        end
        check("abort_cpu_issue_seen", found, 1);
        @(posedge clk); #1;
        reset   = 1'b1;
        cpu_req = 1'b0;
        #1;
        check("abort_reset_we_n", ram_we_n, 1);
        check("abort_reset_cs_n", ram_cs_n, 1);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check("abort_scan_busy", scan_busy, 0);
        check("abort_cpu_rdata", cpu_rdata, 0);
        acks = 0; valids = 0;
        for (int i = 0; i < 10; i++) begin
            if (cpu_ack)    acks++;
            if (scan_valid) valids++;
            @(posedge clk); #2;
        end
        check("abort_no_cpu_ack",    acks, 0);
        check("abort_no_scan_valid", valids, 0);
        check("abort_busy_stays_low", scan_busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Two-master access controller in front of one 1K x 8 synchronous RAM (registered read, one-cycle read latency, write on the clock edge where `we_n` is low). It time-slices the RAM between a CPU byte port with a request/acknowledge handshake and a burst scanner that streams a block of consecutive bytes to video/motion-object logic. It drives the RAM's `a`, `in`, `cs_n` and `we_n` pins and captures its `out` pin.

## Interface
- `ADDR_W`, 10: RAM address width; addresses wrap modulo 2^ADDR_W.
- `clk` in 1: single clock; the RAM shares it.
- `reset` in 1: synchronous, active-high.
- `cpu_req` in 1: CPU request; held until `cpu_ack`.
- `cpu_we` in 1: 1 = write, 0 = read; stable while `cpu_req` is high.
- `cpu_addr` in ADDR_W: CPU byte address.
- `cpu_wdata` in 8: CPU write data.
- `cpu_ack` out 1: one-cycle completion pulse.
- `cpu_rdata` out 8: read data, valid while `cpu_ack` is high; held until the next read completes.
- `scan_start` in 1: one-cycle burst start pulse.
- `scan_base` in ADDR_W: first burst address.
- `scan_count` in 6: burst length; 0 means 64.
- `scan_busy` out 1: burst in progress.
- `scan_valid` out 1: `scan_data` holds the next burst byte.
- `scan_data` out 8: burst byte.
- `scan_done` out 1: pulse coincident with the last `scan_valid`.
- `ram_a` out ADDR_W, `ram_in` out 8, `ram_cs_n` out 1, `ram_we_n` out 1: RAM pins.
- `ram_out` in 8: RAM registered read data.

## Operation
- The slot bit resets to 0 and toggles every cycle. Slot 0 belongs to the scanner and slot 1 to the CPU. The CPU may also use a slot-0 cycle when the scanner has no read to issue in that cycle.
- An issue cycle drives `ram_cs_n`=0, `ram_a`=address, `ram_in`=`cpu_wdata`, and `ram_we_n`=0 only for a CPU write. The RAM writes whenever `we_n` is low, so `ram_we_n` must be 1 in every other cycle, including during reset. In non-issue cycles `ram_cs_n`=1 and `ram_a`=0.
- CPU FSM states:
  - IDLE: `cpu_req` high and slot granted -> issue. The FSM goes to WR_ACK on a write and to RD_WAIT on a read.
  - WR_ACK: assert `cpu_ack` -> HOLD.
  - RD_WAIT: latch `ram_out` into `cpu_rdata` -> RD_ACK.
  - RD_ACK: assert `cpu_ack` -> HOLD.
  - HOLD: one cycle with `cpu_req` ignored -> IDLE.
  - A request therefore issues at the earliest 2 cycles after the previous `cpu_ack`.
- Scanner:
  - `scan_start` while `scan_busy`=0 latches the base address and the count (0 -> 64) and sets `scan_busy` the next cycle.
  - `scan_start` while busy is ignored.
  - Each slot-0 cycle with bytes remaining issues a read at the current address, increments the address modulo 2^ADDR_W and decrements the remaining count.
  - Each issued read yields `scan_valid` 2 cycles later, with `scan_data` = the captured `ram_out`.
  - `scan_done` pulses with the final `scan_valid`. `scan_busy` drops the cycle after it.
- CPU and scanner never issue in the same cycle.
- A CPU write followed by a scanner read of the same address returns the new data.
- Reset in any cycle:
  - aborts the CPU transaction and the burst;
  - discards in-flight read data;
  - suppresses the pending `cpu_ack`/`scan_valid`/`scan_done`.

## Timing
- Reset values: `cpu_ack`=0, `cpu_rdata`=0, `scan_busy`=0, `scan_valid`=0, `scan_data`=0, `scan_done`=0, `ram_cs_n`=1, `ram_we_n`=1, `ram_a`=0, `ram_in`=0. Slot bit = 0, CPU FSM = IDLE.
- CPU read latency: issue cycle C, `ram_out` valid in C+1, `cpu_ack` and `cpu_rdata` in C+2.
- CPU write: written at the end of C, `cpu_ack` in C+1.
- CPU worst-case wait from request to issue is 1 cycle while a burst runs and 0 cycles otherwise.
- Scanner: `scan_start` in cycle S, busy from S+1. Each issue is on a slot-0 cycle, at most one per 2 cycles, with `scan_valid` 2 cycles after each issue. An N-byte burst delivers N `scan_valid` pulses spaced exactly 2 cycles apart.
- `scan_start` in the same cycle as `scan_done` is ignored, because busy is still high.

## Test plan
- Reset -> all outputs at their reset values; `ram_we_n`=1 throughout reset, even with `cpu_req`=1 and `cpu_we`=1 held.
- CPU write 0x5A to 0x123, then a read of 0x123 -> write `cpu_ack` 1 cycle after issue; read `cpu_ack` 2 cycles after issue with `cpu_rdata`=0x5A.
- Preload 0x3FE..0x001 with 0x10..0x13 and start a burst with base 0x3FE, count 4 -> `scan_data` 0x10, 0x11, 0x12, 0x13 on valids 2 cycles apart; `ram_a` wraps 0x3FF -> 0x000; `scan_done` on the 4th valid.
- `scan_count`=0 -> exactly 64 valids; a `scan_start` pulse mid-burst changes nothing.
- CPU read request held during a 16-byte burst -> issue lands on a slot-1 cycle; burst valid spacing stays 2; `cpu_rdata` is correct; no cycle has two issuers.
- Reset asserted in the RD_WAIT cycle and during the burst -> no `cpu_ack`, no further `scan_valid`; `scan_busy`=0 the cycle after reset.
